// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared arbiter definitions: lock state encodings and index helpers.
// Used by fifo_wr_arbiter and its round-robin picker.
package fifo_wr_arbiter_pkg;

    localparam logic IDLE   = 1'b0;
    localparam logic LOCKED = 1'b1;

    // Width of an index field able to hold 0..n-1 (at least 1 bit).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Increment modulo n with an explicit wrap, so non-power-of-2 n is safe.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after rr_ptr, scanning mod N.
// Purely combinational; no state, no backpressure of its own.
// Caller decides whether the pick is actually granted.
module rr_pick #(
    parameter int N  = 4,
    parameter int NW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [NW-1:0] rr_ptr,
    output logic [N-1:0]  pick,
    output logic [NW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        j    = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && req[j]) begin
                any     = 1'b1;
                idx     = NW'(j);
                pick[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing one fifo write port among N requesters.
// Zero latency: grant/fifo_wr/fifo_w_data are combinational from state and inputs.
// fifo_full blocks all grants and freezes state; a locked owner stalls others until its last beat.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int B = 8,
    localparam int NW = clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  last,
    input  logic [N*B-1:0] data,
    output logic [N-1:0]  grant,
    input  logic          fifo_full,
    output logic          fifo_wr,
    output logic [B-1:0]  fifo_w_data,
    output logic          busy,
    output logic [NW-1:0] owner
);

    logic          state;
    logic [NW-1:0] rr_ptr;
    logic [N-1:0]  pick;
    logic [NW-1:0] pick_idx;
    logic          pick_any;
    logic [NW-1:0] sel;

    rr_pick #(.N(N), .NW(NW)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .pick   (pick),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // While locked, only the owner can win, and only when it presents a beat.
    always_comb begin
        grant = '0;
        if (!reset && !fifo_full) begin
            if (state == IDLE) begin
                grant = pick;
            end else begin
                grant[owner] = req[owner];
            end
        end
    end

    assign fifo_wr     = |grant;
    assign sel         = (state == IDLE && fifo_wr) ? pick_idx : owner;
    assign fifo_w_data = data[int'(sel)*B +: B];
    assign busy        = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else if (fifo_wr) begin
            if (state == IDLE) begin
                owner <= pick_idx;
                if (last[pick_idx]) begin
                    rr_ptr <= NW'(wrap_inc(int'(pick_idx), N));
                end else begin
                    state <= LOCKED;
                end
            end else if (last[owner]) begin
                state  <= IDLE;
                rr_ptr <= NW'(wrap_inc(int'(owner), N));
            end
        end
    end

    logic unused_any;
    assign unused_any = pick_any;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against a packet-level model.
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int B = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  grant;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_w_data;
    logic        busy;
    logic [1:0]  owner;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: is a packet in flight, who owns it, who has top priority next.
    int m_locked = 0;
    int m_owner  = 0;
    int m_rr     = 0;

    fifo_wr_arbiter #(.N(N), .B(B)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .last        (last),
        .data        (data),
        .grant       (grant),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_w_data (fifo_w_data),
        .busy        (busy),
        .owner       (owner)
    );

    always #5 clk = ~clk;

    function automatic int winner();
        if (reset || fifo_full) return -1;
        if (m_locked != 0) return req[m_owner] ? m_owner : -1;
        for (int i = 0; i < N; i++) begin
            if (req[(m_rr + i) % N]) return (m_rr + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_grant();
        int w;
        w = winner();
        return (w < 0) ? 4'b0000 : 4'(1 << w);
    endfunction

    task automatic drive(input logic [3:0] rq, input logic [3:0] ls,
                         input logic full, input logic rst);
        req       = rq;
        last      = ls;
        fifo_full = full;
        reset     = rst;
        data      = $urandom;
        #1;
    endtask

    task automatic tick();
        int w;
        int nl, no, nr;
        w  = winner();
        nl = m_locked;
        no = m_owner;
        nr = m_rr;
        if (reset) begin
            nl = 0; no = 0; nr = 0;
        end else if (w >= 0) begin
            no = w;
            if (last[w]) begin
                nl = 0;
                nr = (w + 1) % N;
            end else begin
                nl = 1;
            end
        end
        @(posedge clk);
        #1;
        m_locked = nl;
        m_owner  = no;
        m_rr     = nr;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(4'b1111, 4'b1111, 1'b0, 1'b1);
            vectors++;
            if (grant !== 4'b0000 || fifo_wr !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_outputs cycle=%0d got grant=%b wr=%b want grant=0000 wr=0", c, grant, fifo_wr);
            end
            tick();
        end
        vectors++;
        if (busy !== 1'b0 || owner !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state got busy=%b owner=%0d want busy=0 owner=0", busy, owner);
        end
    endtask

    task automatic test_rotation();
        for (int k = 0; k < 8; k++) begin
            drive(4'b1111, 4'b1111, 1'b0, 1'b0);
            vectors++;
            if (grant !== 4'(1 << (k % 4)) || fifo_wr !== 1'b1) begin
                miscompares++;
                $display("FAIL rotation_grant k=%0d got grant=%b wr=%b want grant=%b wr=1", k, grant, fifo_wr, 4'(1 << (k % 4)));
            end
            vectors++;
            if (fifo_w_data !== data[(k % 4)*8 +: 8]) begin
                miscompares++;
                $display("FAIL rotation_data k=%0d got=%h want=%h", k, fifo_w_data, data[(k % 4)*8 +: 8]);
            end
            tick();
        end
    endtask

    task automatic test_packet_lock();
        for (int b = 0; b < 3; b++) begin
            drive(4'b0101, (b == 2) ? 4'b0101 : 4'b0100, 1'b0, 1'b0);
            vectors++;
            if (grant !== 4'b0001 || fifo_w_data !== data[7:0]) begin
                miscompares++;
                $display("FAIL lock_grant beat=%0d got grant=%b data=%h want grant=0001 data=%h", b, grant, fifo_w_data, data[7:0]);
            end
            vectors++;
            if (busy !== (b != 0)) begin
                miscompares++;
                $display("FAIL lock_busy beat=%0d got=%b want=%b", b, busy, (b != 0));
            end
            tick();
        end
        drive(4'b0100, 4'b0100, 1'b0, 1'b0);
        vectors++;
        if (grant !== 4'b0100 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_handoff got grant=%b busy=%b want grant=0100 busy=0", grant, busy);
        end
        tick();
    endtask

    task automatic test_backpressure();
        drive(4'b0010, 4'b0000, 1'b0, 1'b0);
        vectors++;
        if (grant !== 4'b0010) begin
            miscompares++;
            $display("FAIL bp_first got=%b want=0010", grant);
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(4'b1111, 4'b1111, 1'b1, 1'b0);
            vectors++;
            if (grant !== 4'b0000 || fifo_wr !== 1'b0 || owner !== 2'd1 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold cycle=%0d got grant=%b wr=%b owner=%0d busy=%b want 0000 0 1 1", c, grant, fifo_wr, owner, busy);
            end
            tick();
        end
        drive(4'b1111, 4'b1111, 1'b0, 1'b0);
        vectors++;
        if (grant !== 4'b0010 || fifo_w_data !== data[15:8]) begin
            miscompares++;
            $display("FAIL bp_resume got grant=%b data=%h want grant=0010 data=%h", grant, fifo_w_data, data[15:8]);
        end
        tick();
    endtask

    task automatic test_owner_gap();
        drive(4'b1000, 4'b0000, 1'b0, 1'b0);
        vectors++;
        if (grant !== 4'b1000) begin
            miscompares++;
            $display("FAIL gap_first got=%b want=1000", grant);
        end
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(4'b0001, 4'b0001, 1'b0, 1'b0);
            vectors++;
            if (grant !== 4'b0000 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL gap_stall cycle=%0d got grant=%b busy=%b want grant=0000 busy=1", c, grant, busy);
            end
            tick();
        end
        drive(4'b1001, 4'b1000, 1'b0, 1'b0);
        vectors++;
        if (grant !== 4'b1000) begin
            miscompares++;
            $display("FAIL gap_last got=%b want=1000", grant);
        end
        tick();
        drive(4'b1111, 4'b1111, 1'b0, 1'b0);
        vectors++;
        if (grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL gap_wrap got=%b want=0001", grant);
        end
        tick();
    endtask

    task automatic test_reset_mid_packet();
        drive(4'b0100, 4'b0000, 1'b0, 1'b0);
        tick();
        vectors++;
        if (busy !== 1'b1 || owner !== 2'd2) begin
            miscompares++;
            $display("FAIL rmp_locked got busy=%b owner=%0d want busy=1 owner=2", busy, owner);
        end
        drive(4'b1111, 4'b0000, 1'b0, 1'b1);
        vectors++;
        if (grant !== 4'b0000) begin
            miscompares++;
            $display("FAIL rmp_during got=%b want=0000", grant);
        end
        tick();
        drive(4'b1111, 4'b1111, 1'b0, 1'b0);
        vectors++;
        if (busy !== 1'b0 || owner !== 2'd0 || grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL rmp_after got busy=%b owner=%0d grant=%b want busy=0 owner=0 grant=0001", busy, owner, grant);
        end
        tick();
    endtask

    task automatic test_random();
        logic [3:0] eg;
        for (int c = 0; c < 600; c++) begin
            drive(4'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 59) == 0);
            eg = exp_grant();
            vectors++;
            if (grant !== eg || fifo_wr !== (eg != 4'b0000)) begin
                miscompares++;
                $display("FAIL rand_grant c=%0d got grant=%b wr=%b want grant=%b wr=%b", c, grant, fifo_wr, eg, (eg != 4'b0000));
            end
            if (eg != 4'b0000) begin
                vectors++;
                if (fifo_w_data !== data[winner()*8 +: 8]) begin
                    miscompares++;
                    $display("FAIL rand_data c=%0d got=%h want=%h", c, fifo_w_data, data[winner()*8 +: 8]);
                end
            end
            vectors++;
            if (busy !== (m_locked != 0) || owner !== 2'(m_owner)) begin
                miscompares++;
                $display("FAIL rand_state c=%0d got busy=%b owner=%0d want busy=%b owner=%0d", c, busy, owner, (m_locked != 0), m_owner);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();
        test_rotation();
        test_packet_lock();
        test_backpressure();
        test_owner_gap();
        test_reset_mid_packet();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
